// File: rtl/axi_reg_sequencer.sv
// Round-robin sharing of one AXI register slave between NM req/ack requesters.
// One transaction in flight at a time: AW+W -> B, or AR -> R.
//
// state   | meaning
// --------+-----------------------------------------------------
// S_IDLE  | wait for any request, pick next requester round-robin
// S_WR    | AW and W channels open, each drops once handshaken
// S_WRESP | bready high, waiting for write response
// S_RADDR | arvalid high, waiting for arready
// S_RDATA | rready high, waiting for read data
// S_ACK   | one-cycle ack to granted requester, advance rr pointer
module axi_reg_sequencer #(
  parameter int NM = 2,
  parameter int AW = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*32-1:0] m_wdata_i,
  input  logic [NM*4-1:0]  m_wstrb_i,
  output logic [NM-1:0]    m_ack_o,
  output logic             m_err_o,
  output logic [31:0]      m_rdata_o,
  output logic [AW-1:0]    s_awaddr_o,
  output logic             s_awvalid_o,
  input  logic             s_awready_i,
  output logic [31:0]      s_wdata_o,
  output logic [3:0]       s_wstrb_o,
  output logic             s_wvalid_o,
  input  logic             s_wready_i,
  input  logic [1:0]       s_bresp_i,
  input  logic             s_bvalid_i,
  output logic             s_bready_o,
  output logic [AW-1:0]    s_araddr_o,
  output logic             s_arvalid_o,
  input  logic             s_arready_i,
  input  logic [31:0]      s_rdata_i,
  input  logic             s_rvalid_i,
  output logic             s_rready_o
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [GW:0] NM_W = (GW+1)'(NM);
  localparam logic [GW-1:0] LAST = GW'(NM-1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_ACK
  } state_t;

  state_t state, state_nxt;

  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   grant_inc;
  logic [GW:0]     pick_sum;
  logic [2*NM-1:0] req_dbl;
  logic            any_req;
  logic            found;

  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_wstrb;

  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            aw_done;
  logic            w_done;

  logic            aw_hs;
  logic            w_hs;

  assign any_req   = |m_req_i;
  assign req_dbl   = {m_req_i, m_req_i} >> rr_ptr;
  assign grant_inc = (grant == LAST) ? '0 : grant + GW'(1);

  // Rotated request vector: bit j corresponds to requester rr_ptr+j (mod NM).
  always_comb begin
    pick     = rr_ptr;
    pick_sum = '0;
    found    = 1'b0;
    for (int j = 0; j < NM; j++) begin
      if (!found && req_dbl[j]) begin
        found    = 1'b1;
        pick_sum = {1'b0, rr_ptr} + (GW+1)'(j);
        if (pick_sum >= NM_W) pick_sum = pick_sum - NM_W;
        pick     = pick_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < NM; k++) begin
      if (pick == GW'(k)) begin
        sel_we    = m_we_i[k];
        sel_addr  = m_addr_i[k*AW +: AW];
        sel_wdata = m_wdata_i[k*32 +: 32];
        sel_wstrb = m_wstrb_i[k*4 +: 4];
      end
    end
  end

  assign aw_hs = s_awvalid_o & s_awready_i;
  assign w_hs  = s_wvalid_o & s_wready_i;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = sel_we ? S_WR : S_RADDR;
      S_WR:    if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = S_WRESP;
      S_WRESP: if (s_bvalid_i) state_nxt = S_ACK;
      S_RADDR: if (s_arready_i) state_nxt = S_RDATA;
      S_RDATA: if (s_rvalid_i) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_awvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    m_ack_o     = '0;
    m_err_o     = 1'b0;
    case (state)
      S_WR: begin
        s_awvalid_o = !aw_done;
        s_wvalid_o  = !w_done;
      end
      S_WRESP: s_bready_o  = 1'b1;
      S_RADDR: s_arvalid_o = 1'b1;
      S_RDATA: s_rready_o  = 1'b1;
      S_ACK: begin
        for (int k = 0; k < NM; k++) m_ack_o[k] = (grant == GW'(k));
        m_err_o = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rr_ptr  <= '0;
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant   <= pick;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        S_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        S_WRESP: begin
          if (s_bvalid_i) err_q <= (s_bresp_i != 2'b00);
        end
        S_RDATA: begin
          if (s_rvalid_i) begin
            rdata_q <= s_rdata_i;
            err_q   <= 1'b0;
          end
        end
        S_ACK: rr_ptr <= grant_inc;
        default: ;
      endcase
    end
  end

  // Address serves both channels; only the relevant valid is ever raised.
  assign s_awaddr_o = addr_q;
  assign s_araddr_o = addr_q;
  assign s_wdata_o  = wdata_q;
  assign s_wstrb_o  = wstrb_q;
  assign m_rdata_o  = rdata_q;

endmodule

// File: tb/tb_axi_reg_sequencer.sv
// Directed bench for axi_reg_sequencer: vector table of single transactions
// plus hand sequences for round-robin, ignored responses and mid-flight reset.
module tb_axi_reg_sequencer;

  localparam int NM = 2;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             areset = 1'b0;
  logic [NM-1:0]    m_req_i = '0;
  logic [NM-1:0]    m_we_i = '0;
  logic [NM*AW-1:0] m_addr_i = '0;
  logic [NM*32-1:0] m_wdata_i = '0;
  logic [NM*4-1:0]  m_wstrb_i = '0;
  logic [NM-1:0]    m_ack_o;
  logic             m_err_o;
  logic [31:0]      m_rdata_o;
  logic [AW-1:0]    s_awaddr_o;
  logic             s_awvalid_o;
  logic             s_awready_i = 1'b0;
  logic [31:0]      s_wdata_o;
  logic [3:0]       s_wstrb_o;
  logic             s_wvalid_o;
  logic             s_wready_i = 1'b0;
  logic [1:0]       s_bresp_i = '0;
  logic             s_bvalid_i = 1'b0;
  logic             s_bready_o;
  logic [AW-1:0]    s_araddr_o;
  logic             s_arvalid_o;
  logic             s_arready_i = 1'b0;
  logic [31:0]      s_rdata_i = '0;
  logic             s_rvalid_i = 1'b0;
  logic             s_rready_o;

  axi_reg_sequencer #(.NM(NM), .AW(AW)) dut (
    .clk(clk), .areset(areset),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
    .s_awaddr_o(s_awaddr_o), .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
    .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wvalid_o(s_wvalid_o),
    .s_wready_i(s_wready_i), .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i),
    .s_bready_o(s_bready_o), .s_araddr_o(s_araddr_o), .s_arvalid_o(s_arvalid_o),
    .s_arready_i(s_arready_i), .s_rdata_i(s_rdata_i), .s_rvalid_i(s_rvalid_i),
    .s_rready_o(s_rready_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit          we;
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          d_a;     // extra cycles before awready/arready
    int          d_w;     // extra cycles before wready
    int          d_r;     // extra cycles before bvalid/rvalid
    logic [1:0]  bresp;
    logic [31:0] rdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_output();
    return |{m_ack_o, m_err_o, m_rdata_o, s_awaddr_o, s_awvalid_o, s_wdata_o,
             s_wstrb_o, s_wvalid_o, s_bready_o, s_araddr_o, s_arvalid_o, s_rready_o};
  endfunction

  task automatic clear_slave();
    s_awready_i = 1'b0;
    s_wready_i  = 1'b0;
    s_bvalid_i  = 1'b0;
    s_bresp_i   = 2'b00;
    s_arready_i = 1'b0;
    s_rvalid_i  = 1'b0;
    s_rdata_i   = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    bit done = 1'b0;
    m_we_i[v.m]            = v.we;
    m_addr_i[v.m*AW +: AW] = v.addr;
    m_wdata_i[v.m*32 +: 32] = v.wdata;
    m_wstrb_i[v.m*4 +: 4]  = v.wstrb;
    m_req_i[v.m]           = 1'b1;
    @(negedge clk);
    check("first_valid", 64'({s_awvalid_o, s_wvalid_o, s_arvalid_o}),
          v.we ? 64'(3'b110) : 64'(3'b001));
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (s_awvalid_o) begin
        aw_n++;
        check("awaddr", 64'(s_awaddr_o), 64'(v.addr));
      end
      s_awready_i = s_awvalid_o && (aw_n > v.d_a);
      if (s_wvalid_o) begin
        w_n++;
        check("wdata_wstrb", 64'({s_wdata_o, s_wstrb_o}), 64'({v.wdata, v.wstrb}));
      end
      s_wready_i = s_wvalid_o && (w_n > v.d_w);
      if (s_arvalid_o) begin
        ar_n++;
        check("araddr", 64'(s_araddr_o), 64'(v.addr));
      end
      s_arready_i = s_arvalid_o && (ar_n > v.d_a);
      if (s_bready_o) b_n++;
      s_bvalid_i = s_bready_o && (b_n > v.d_r);
      s_bresp_i  = v.bresp;
      if (s_rready_o) r_n++;
      s_rvalid_i = s_rready_o && (r_n > v.d_r);
      s_rdata_i  = v.rdata;
      if (m_ack_o != '0) begin
        check("ack_onehot", 64'(m_ack_o), 64'(1 << v.m));
        check("ack_err", 64'(m_err_o), 64'(v.exp_err));
        if (!v.we) check("ack_rdata", 64'(m_rdata_o), 64'(v.rdata));
        m_req_i[v.m] = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) check("ack_timeout", 64'(0), 64'(1));
    if (v.we) begin
      check("aw_cycles", 64'(aw_n), 64'(v.d_a + 1));
      check("w_cycles", 64'(w_n), 64'(v.d_w + 1));
      check("bready_cycles", 64'(b_n), 64'(v.d_r + 1));
    end else begin
      check("ar_cycles", 64'(ar_n), 64'(v.d_a + 1));
      check("rready_cycles", 64'(r_n), 64'(v.d_r + 1));
    end
    @(negedge clk);
    clear_slave();
    check("ack_single_cycle", 64'(m_ack_o), 64'(0));
    check("rdata_held", 64'(m_rdata_o), 64'(v.exp_rdata));
  endtask

  task automatic pulse_reset();
    areset = 1'b0;
    m_req_i = '0;
    clear_slave();
    repeat (2) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NM-1:0] exp_order [4];
    int n;
    int pending;
    bit seen;

    //        we   m  addr          wdata          strb  da dw dr bresp  rdata          err  exp_rdata
    vecs[0] = '{1'b1, 0, 32'h0000_0003, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,          1'b0, 32'h0};
    vecs[1] = '{1'b1, 0, 32'h0000_0010, 32'hA5A5_0001, 4'h3, 0, 3, 0, 2'b00, 32'h0,          1'b0, 32'h0};
    vecs[2] = '{1'b0, 1, 32'h0000_0002, 32'h0,         4'h0, 0, 0, 2, 2'b00, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[3] = '{1'b1, 0, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 2, 0, 1, 2'b10, 32'h0,          1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 1, 32'h0000_0024, 32'h1122_3344, 4'hC, 1, 1, 0, 2'b00, 32'h0,          1'b0, 32'h1234_5678};
    vecs[5] = '{1'b0, 0, 32'h0000_0030, 32'h0,         4'h0, 2, 0, 0, 2'b00, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1, 32'h0000_0040, 32'h0000_00FF, 4'h1, 0, 0, 0, 2'b01, 32'h0,          1'b1, 32'hCAFE_F00D};

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", 64'(any_output()), 64'(0));
    areset = 1'b1;
    @(negedge clk);
    check("idle_outputs_zero", 64'(any_output()), 64'(0));

    // Both requesters continuously requesting reads from reset
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    m_we_i   = '0;
    m_addr_i = {32'h0000_0200, 32'h0000_0100};
    m_req_i  = 2'b11;
    n = 0;
    pending = -1;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (pending >= 0) begin
        m_req_i[pending] = 1'b1;
        pending = -1;
      end
      s_arready_i = s_arvalid_o;
      s_rvalid_i  = s_rready_o;
      s_rdata_i   = 32'h1000 + 32'(n);
      if (m_ack_o != '0) begin
        check("rr_onehot", 64'($onehot(m_ack_o)), 64'(1));
        check("rr_order", 64'(m_ack_o), 64'(exp_order[n]));
        pending = m_ack_o[1] ? 1 : 0;
        n++;
        if (n == 4) m_req_i = '0;
        else        m_req_i = m_req_i & ~m_ack_o;
      end
    end
    check("rr_txn_count", 64'(n), 64'(4));
    @(negedge clk);
    clear_slave();
    pulse_reset();
    check("rdata_cleared_by_reset", 64'(m_rdata_o), 64'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Responses outside WRESP/RDATA are ignored
    s_bvalid_i = 1'b1;
    s_bresp_i  = 2'b10;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hFFFF_FFFF;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack_o != '0 || s_bready_o || s_rready_o) seen = 1'b1;
    end
    check("stray_response_ignored", 64'(seen), 64'(0));
    check("stray_rdata_not_captured", 64'(m_rdata_o), 64'(32'hCAFE_F00D));
    clear_slave();

    // Reset while waiting for the write response
    m_we_i[0] = 1'b1;
    m_addr_i[0 +: AW] = 32'h0000_0005;
    m_wdata_i[0 +: 32] = 32'h5555_AAAA;
    m_wstrb_i[0 +: 4] = 4'hF;
    m_req_i[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      s_awready_i = s_awvalid_o;
      s_wready_i  = s_wvalid_o;
      if (s_bready_o) seen = 1'b1;
    end
    check("reached_wresp", 64'(seen), 64'(1));
    areset = 1'b0;
    s_bvalid_i = 1'b1;
    #1;
    check("async_reset_outputs_zero", 64'(any_output()), 64'(0));
    m_req_i = '0;
    @(negedge clk);
    check("no_ack_in_reset", 64'(m_ack_o), 64'(0));
    clear_slave();
    areset = 1'b1;
    @(negedge clk);
    check("no_ack_after_reset", 64'(m_ack_o), 64'(0));
    run_vec('{1'b0, 1, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 1, 2'b00,
              32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
